// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between the byte producer, uart_tx_feeder and the UART transmitter.
// slave is the feeder side, master is the producer/transmitter side.
interface uart_tx_feeder_if #(
    parameter int ADDR_W = 4
);
    logic            wr_en;
    logic [7:0]      wr_data;
    logic [4:0]      wr_lcr;
    logic            err_clr;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic [7:0]      tx_data;
    logic [4:0]      tx_lcr;
    logic            tx_start;
    logic            tx_active;
    logic            tx_done;
    logic            busy;
    logic            overflow;
    logic            timeout_err;

    modport slave (
        input  wr_en, wr_data, wr_lcr, err_clr, tx_active, tx_done,
        output full, empty, count, tx_data, tx_lcr, tx_start,
        output busy, overflow, timeout_err
    );

    modport master (
        output wr_en, wr_data, wr_lcr, err_clr, tx_active, tx_done,
        input  full, empty, count, tx_data, tx_lcr, tx_start,
        input  busy, overflow, timeout_err
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame sequencer feeding a UART transmitter one byte at a time.
// Each byte carries its own line-control word; a start pulse launches each frame.
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 65535
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_feeder_if.slave io_bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [ADDR_W:0] L_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]     L_TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]      L_GAP     = 8'(GAP_CYCLES);

    logic [12:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [2:0]        r_state;
    logic [7:0]        r_tx_data;
    logic [4:0]        r_tx_lcr;
    logic              r_tx_start;
    logic [15:0]       r_tcnt;
    logic [7:0]        r_gcnt;
    logic              r_done_held;
    logic              r_overflow;
    logic              r_timeout_err;

    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_done;
    logic        w_to_hit;
    logic [12:0] w_head;
    logic        w_unused_active;

    assign w_full   = (r_count == L_DEPTH);
    assign w_push   = io_bus.wr_en & ~w_full;
    assign w_drop   = io_bus.wr_en & w_full;
    assign w_pop    = (r_state == S_LOAD);
    assign w_done   = io_bus.tx_done | r_done_held;
    assign w_to_hit = (r_state == S_WAIT) & ~w_done & (r_tcnt == L_TO_LAST);
    assign w_head   = r_mem[r_rd_ptr];

    // The transmitter's active flag is observed only; it does not steer the FSM.
    assign w_unused_active = io_bus.tx_active;

    assign io_bus.full        = w_full;
    assign io_bus.empty       = (r_count == '0);
    assign io_bus.count       = r_count;
    assign io_bus.tx_data     = r_tx_data;
    assign io_bus.tx_lcr      = r_tx_lcr;
    assign io_bus.tx_start    = r_tx_start;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.overflow    = r_overflow;
    assign io_bus.timeout_err = r_timeout_err;

    // FIFO storage; contents are discarded on reset through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {io_bus.wr_lcr, io_bus.wr_data};
        end
    end

    // Write pointer and occupancy; a pop and a push in one cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (ADDR_W + 1)'(1);
            end
        end
    end

    // Frame sequencer: load head byte, pulse start, wait for done, optional gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_tx_data   <= '0;
            r_tx_lcr    <= '0;
            r_tx_start  <= 1'b0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
            r_done_held <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_data  <= w_head[7:0];
                    r_tx_lcr   <= w_head[12:8];
                    r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                    r_tx_start <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_tx_start  <= 1'b0;
                    r_tcnt      <= '0;
                    r_done_held <= io_bus.tx_done;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done || (r_tcnt == L_TO_LAST)) begin
                        r_done_held <= 1'b0;
                        r_gcnt      <= L_GAP;
                        r_state     <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_gcnt <= 8'd1) begin
                        r_gcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end
endmodule
